// File: rtl/game_flow_fsm_pkg.sv
// Shared types and constants for the Digger game sequencer.
// Holds the state encoding, default pause lengths and the level counter helper.
package game_flow_pkg;

    localparam int LEVEL_W = 4;

    localparam int DEF_DEATH_FRAMES    = 120;
    localparam int DEF_LEVEL_FRAMES    = 90;
    localparam int DEF_GAMEOVER_FRAMES = 180;
    localparam int DEF_MAX_LEVEL       = 8;

    // The encoding doubles as the debug state_code shown on HEX/LEDs.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_PLAY     = 3'd2,
        ST_DEATH    = 3'd3,
        ST_LVL_DONE = 3'd4,
        ST_OVER     = 3'd5
    } game_state_t;

    function automatic logic [LEVEL_W-1:0] level_sat_inc(input logic [LEVEL_W-1:0] lvl,
                                                         input logic [LEVEL_W-1:0] max_lvl);
        return (lvl >= max_lvl) ? max_lvl : lvl + LEVEL_W'(1);
    endfunction

endpackage

// File: rtl/game_flow_fsm_if.sv
// Bundle of game events in and screen/reset controls out of the sequencer.
// The sequencer uses the slave view; the controller/mux side uses master.
interface game_flow_fsm_if;
    import game_flow_pkg::*;

    logic               startOfFrame;
    logic               start_btn;
    logic               player_died;
    logic               level_cleared;
    logic               no_lives;
    logic               game_resetN;
    logic               freeze;
    logic               show_title;
    logic               show_game_over;
    logic [LEVEL_W-1:0] level_num;
    logic [2:0]         state_code;

    modport master (
        output startOfFrame, start_btn, player_died, level_cleared, no_lives,
        input  game_resetN, freeze, show_title, show_game_over, level_num, state_code
    );

    modport slave (
        input  startOfFrame, start_btn, player_died, level_cleared, no_lives,
        output game_resetN, freeze, show_title, show_game_over, level_num, state_code
    );

endinterface

// File: rtl/game_flow_fsm_frame_timer.sv
// Counts frame strobes up to a target; done fires on the target-th strobe.
// Held at zero whenever clear is high, so the owner clears it on state entry.
module frame_timer (
    input  logic       clk,
    input  logic       resetN,
    input  logic       clear,
    input  logic       tick,
    input  logic [7:0] target,
    output logic       done
);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (tick) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = tick && (count_q == target - 8'd1);

endmodule

// File: rtl/game_flow_fsm.sv
// Top-level game sequencer: title, level load, play, death/level pauses, game over.
// Drives the managed game reset, freeze and screen-select flags from the state register.
module game_flow_fsm
    import game_flow_pkg::*;
#(
    parameter int DEATH_FRAMES    = DEF_DEATH_FRAMES,
    parameter int LEVEL_FRAMES    = DEF_LEVEL_FRAMES,
    parameter int GAMEOVER_FRAMES = DEF_GAMEOVER_FRAMES,
    parameter int MAX_LEVEL       = DEF_MAX_LEVEL
) (
    input  logic            clk,
    input  logic            resetN,
    game_flow_fsm_if.slave  bus
);

    localparam logic [7:0]         DEATH_T = 8'(DEATH_FRAMES);
    localparam logic [7:0]         LEVEL_T = 8'(LEVEL_FRAMES);
    localparam logic [7:0]         OVER_T  = 8'(GAMEOVER_FRAMES);
    localparam logic [LEVEL_W-1:0] MAX_LVL = LEVEL_W'(MAX_LEVEL);

    game_state_t        state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               start_dly_q;
    logic               start_rise;
    logic               timed;
    logic               timer_clear;
    logic               timer_done;
    logic [7:0]         timer_target;

    assign start_rise = bus.start_btn & ~start_dly_q;
    assign timed      = (state_q == ST_DEATH) || (state_q == ST_LVL_DONE) || (state_q == ST_OVER);
    // Every exit from a paused state goes through timer_done, so clearing on it covers entry.
    assign timer_clear = !timed || timer_done;

    always_comb begin
        timer_target = 8'd1;
        case (state_q)
            ST_DEATH:    timer_target = DEATH_T;
            ST_LVL_DONE: timer_target = LEVEL_T;
            ST_OVER:     timer_target = OVER_T;
            default:     timer_target = 8'd1;
        endcase
    end

    frame_timer u_timer (
        .clk    (clk),
        .resetN (resetN),
        .clear  (timer_clear),
        .tick   (bus.startOfFrame),
        .target (timer_target),
        .done   (timer_done)
    );

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d = ST_LOAD;
                    level_d = LEVEL_W'(1);
                end
            end
            ST_LOAD:  if (bus.startOfFrame) state_d = ST_PLAY;
            ST_PLAY: begin
                if (bus.player_died)        state_d = ST_DEATH;
                else if (bus.level_cleared) state_d = ST_LVL_DONE;
            end
            ST_DEATH: if (timer_done) state_d = bus.no_lives ? ST_OVER : ST_PLAY;
            ST_LVL_DONE: begin
                if (timer_done) begin
                    state_d = ST_LOAD;
                    level_d = level_sat_inc(level_q, MAX_LVL);
                end
            end
            ST_OVER:  if (timer_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_IDLE;
            level_q     <= LEVEL_W'(1);
            start_dly_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            start_dly_q <= bus.start_btn;
        end
    end

    assign bus.game_resetN    = !((state_q == ST_IDLE) || (state_q == ST_LOAD));
    assign bus.freeze         = timed;
    assign bus.show_title     = (state_q == ST_IDLE);
    assign bus.show_game_over = (state_q == ST_OVER);
    assign bus.level_num      = level_q;
    assign bus.state_code     = state_q;

endmodule
